// File: rtl/tbcm_crc_scheduler_if.sv
// Requester beat bus plus CRC result port for tbcm_crc_scheduler.
interface tbcm_crc_scheduler_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CRC_WIDTH  = 32
);
    localparam int unsigned ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]                 i_valid;
    logic [N_REQ-1:0]                 o_ready;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] i_data;
    logic [N_REQ-1:0]                 i_last;
    logic                             o_crc_valid;
    logic                             i_crc_ready;
    logic [CRC_WIDTH-1:0]             o_crc;
    logic [ID_WIDTH-1:0]              o_crc_id;

    // Requesters and result consumer side.
    modport master (
        output i_valid, i_data, i_last, i_crc_ready,
        input  o_ready, o_crc_valid, o_crc, o_crc_id
    );

    // Scheduler side.
    modport slave (
        input  i_valid, i_data, i_last, i_crc_ready,
        output o_ready, o_crc_valid, o_crc, o_crc_id
    );
endinterface

// File: rtl/tbcm_crc_scheduler.sv
// Round-robin frame scheduler sharing one parallel CRC datapath among requesters.
package tbcm_crc_pkg;
    typedef enum logic [1:0] {
        TBCM_CRC_8  = 2'd0,
        TBCM_CRC_16 = 2'd1,
        TBCM_CRC_32 = 2'd2
    } crc_type_e;

    function automatic int unsigned get_crc_width(crc_type_e crc_type);
        case (crc_type)
            TBCM_CRC_8:  return 8;
            TBCM_CRC_16: return 16;
            default:     return 32;
        endcase
    endfunction

    function automatic logic [63:0] get_crc_polynomial(crc_type_e crc_type);
        case (crc_type)
            TBCM_CRC_8:  return 64'h07;
            TBCM_CRC_16: return 64'h1021;
            default:     return 64'h04C1_1DB7;
        endcase
    endfunction
endpackage

module tbcm_crc_scheduler
    import tbcm_crc_pkg::*;
#(
    parameter int unsigned          N_REQ          = 4,
    parameter int unsigned          DATA_WIDTH     = 8,
    parameter crc_type_e            CRC_TYPE       = TBCM_CRC_32,
    parameter int unsigned          CRC_WIDTH      = get_crc_width(CRC_TYPE),
    parameter logic [CRC_WIDTH-1:0] CRC_POLYNOMIAL = CRC_WIDTH'(get_crc_polynomial(CRC_TYPE)),
    parameter logic [CRC_WIDTH-1:0] CRC_INIT       = '0,
    parameter logic [CRC_WIDTH-1:0] CRC_XOR_OUT    = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    tbcm_crc_scheduler_if.slave bus
);
    localparam int unsigned ID_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ID_WIDTH-1:0]     gnt_q;
    logic [ID_WIDTH-1:0]     rr_q;
    logic [N_REQ-1:0]        ready_q;
    logic [CRC_WIDTH-1:0]    crc_q;
    logic                    crc_valid_q;
    logic [CRC_WIDTH-1:0]    crc_out_q;
    logic [ID_WIDTH-1:0]     crc_id_q;

    logic [2*N_REQ-1:0]      valid_dbl_c;
    logic [N_REQ-1:0]        valid_rot_c;
    logic                    grant_found_c;
    int unsigned             grant_off_c;
    int unsigned             grant_sum_c;
    int unsigned             rr_sum_c;
    logic [ID_WIDTH-1:0]     grant_idx_c;
    logic [ID_WIDTH-1:0]     rr_next_c;
    logic                    beat_acc_c;
    logic [DATA_WIDTH-1:0]   beat_data_c;
    logic                    beat_last_c;
    logic [CRC_WIDTH-1:0]    crc_next_c;

    // MSB-first, non-reflected CRC over one beat. Feeding data bits into the
    // register top is the same as remainder((data ^ crc<<(DW-CW)) * x^CW) when
    // DATA_WIDTH >= CRC_WIDTH, and still correct for narrower beats.
    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  crc_in,
        input logic [DATA_WIDTH-1:0] data_in
    );
        logic [CRC_WIDTH-1:0]  r;
        logic [DATA_WIDTH-1:0] d;
        logic                  fb;
        r = crc_in;
        d = data_in;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            fb = r[CRC_WIDTH-1] ^ d[DATA_WIDTH-1];
            r  = r << 1;
            d  = d << 1;
            if (fb) begin
                r = r ^ CRC_POLYNOMIAL;
            end
        end
        return r;
    endfunction

    // Round-robin search: rotate valids so bit 0 is the rr pointer, take the first set bit.
    always_comb begin
        valid_dbl_c   = {bus.i_valid, bus.i_valid};
        valid_rot_c   = N_REQ'(valid_dbl_c >> rr_q);
        grant_found_c = 1'b0;
        grant_off_c   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_found_c && valid_rot_c[k]) begin
                grant_found_c = 1'b1;
                grant_off_c   = k;
            end
        end
        grant_sum_c = 32'(rr_q) + grant_off_c;
        if (grant_sum_c >= N_REQ) begin
            grant_sum_c = grant_sum_c - N_REQ;
        end
        grant_idx_c = ID_WIDTH'(grant_sum_c);
        rr_sum_c    = grant_sum_c + 1;
        if (rr_sum_c >= N_REQ) begin
            rr_sum_c = 0;
        end
        rr_next_c = ID_WIDTH'(rr_sum_c);
    end

    // Beat acceptance and next CRC for the granted requester.
    always_comb begin
        beat_acc_c  = |(bus.i_valid & ready_q);
        beat_data_c = bus.i_data[gnt_q];
        beat_last_c = bus.i_last[gnt_q];
        crc_next_c  = crc_step(crc_q, beat_data_c);
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            ready_q     <= '0;
            crc_q       <= CRC_INIT;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            crc_id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found_c) begin
                        gnt_q   <= grant_idx_c;
                        rr_q    <= rr_next_c;
                        crc_q   <= CRC_INIT;
                        ready_q <= N_REQ'(1) << grant_idx_c;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat_acc_c) begin
                        crc_q <= crc_next_c;
                        if (beat_last_c) begin
                            crc_out_q   <= crc_next_c ^ CRC_XOR_OUT;
                            crc_id_q    <= gnt_q;
                            crc_valid_q <= 1'b1;
                            ready_q     <= '0;
                            state_q     <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    if (bus.i_crc_ready) begin
                        crc_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q     <= '0;
                    crc_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_crc_valid = crc_valid_q;
    assign bus.o_crc       = crc_out_q;
    assign bus.o_crc_id    = crc_id_q;
endmodule
